// File: rtl/ssd_scan_driver.sv
// Four-digit time-multiplexed seven-segment driver for the CPU debug tap.
// Ports: clock, reset_n (async low); data_in/half_sel/data_valid/data_ready
// handshake into a pending buffer; blank_lz live blanking control;
// ssd_out = {anode[3:0], seg[6:0]} (seg = gfedcba); frame_done pulse.
module ssd_scan_driver #(
    parameter int DIV_WIDTH      = 16,
    parameter int DIV_MAX        = 49999,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] data_in,
    input  logic        data_valid,
    output logic        data_ready,
    input  logic        half_sel,
    input  logic        blank_lz,
    output logic [10:0] ssd_out,
    output logic        frame_done
);

    localparam logic [DIV_WIDTH-1:0] DIV_TOP = DIV_WIDTH'(DIV_MAX);
    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
    logic [1:0]           dig_q, dig_d;
    logic [31:0]          active_q, active_d;
    logic                 active_half_q, active_half_d;
    logic [31:0]          pend_q, pend_d;
    logic                 pend_half_q, pend_half_d;
    logic                 pend_full_q, pend_full_d;
    logic                 ready_q, ready_d;
    logic                 frame_done_q, frame_done_d;
    logic [10:0]          ssd_q, ssd_d;

    logic        tick;
    logic        boundary;
    logic        capture;
    logic [15:0] disp16;
    logic [15:0] upper16;
    logic        blank;
    logic [6:0]  seg_on;
    logic [6:0]  seg_drv;
    logic [3:0]  anode;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    always_comb begin
        tick     = (div_cnt_q == DIV_TOP);
        boundary = tick && (dig_q == 2'd3);
        capture  = data_valid && ready_q;

        div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
        dig_d     = tick ? dig_q + 2'd1 : dig_q;

        active_d      = active_q;
        active_half_d = active_half_q;
        pend_d        = pend_q;
        pend_half_d   = pend_half_q;
        pend_full_d   = pend_full_q;

        // Promotion only ever sees a word captured on an earlier edge.
        if (boundary && pend_full_q) begin
            active_d      = pend_q;
            active_half_d = pend_half_q;
            pend_full_d   = 1'b0;
        end
        if (capture) begin
            pend_d      = data_in;
            pend_half_d = half_sel;
            pend_full_d = 1'b1;
        end

        ready_d      = !pend_full_d;
        frame_done_d = boundary;

        disp16  = active_half_q ? active_q[31:16] : active_q[15:0];
        upper16 = disp16 >> {dig_q, 2'b00};
        // Digit 0 always lit so a zero value still shows "0".
        blank   = blank_lz && (dig_q != 2'd0) && (upper16 == 16'h0);
        seg_on  = blank ? 7'h00 : hex7(upper16[3:0]);
        seg_drv = SEG_ACTIVE_LOW ? ~seg_on : seg_on;
        anode   = ~(4'b0001 << dig_q);
        ssd_d   = {anode, seg_drv};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt_q     <= '0;
            dig_q         <= 2'd0;
            active_q      <= 32'h0;
            active_half_q <= 1'b0;
            pend_q        <= 32'h0;
            pend_half_q   <= 1'b0;
            pend_full_q   <= 1'b0;
            ready_q       <= 1'b1;
            frame_done_q  <= 1'b0;
            ssd_q         <= {4'hF, SEG_OFF};
        end else begin
            div_cnt_q     <= div_cnt_d;
            dig_q         <= dig_d;
            active_q      <= active_d;
            active_half_q <= active_half_d;
            pend_q        <= pend_d;
            pend_half_q   <= pend_half_d;
            pend_full_q   <= pend_full_d;
            ready_q       <= ready_d;
            frame_done_q  <= frame_done_d;
            ssd_q         <= ssd_d;
        end
    end

    assign data_ready = ready_q;
    assign frame_done = frame_done_q;
    assign ssd_out    = ssd_q;

endmodule

// File: doc/ssd_scan_driver.md
Name: ssd_scan_driver

Overview:
- Time-multiplexed seven-segment display driver. Sits downstream of the pipeline CPU's debug tap: register-file and PC contents arrive on a 32-bit bus with a valid/ready handshake.
- Drives a 4-digit, common-anode display through the packed 11-bit bus {anode[3:0], seg[6:0]}.
- New values are double-buffered and applied only at frame boundaries, so a word never tears across digits.

Parameters:
- DIV_WIDTH, 16, width of the refresh divider counter.
- DIV_MAX, 49999, divider terminal count; one digit tick every DIV_MAX+1 clocks.
- SEG_ACTIVE_LOW, 1, 1 means segment lines are active-low; 0 means active-high. Anodes are always active-low.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- data_in  in  32  word to display.
- data_valid  in  1  data_in/half_sel are valid this cycle.
- data_ready  out  1  pending buffer empty; transfer occurs when data_valid && data_ready.
- half_sel  in  1  captured with data_in: 0 shows data_in[15:0], 1 shows data_in[31:16].
- blank_lz  in  1  live, uncaptured control: enables leading-zero blanking.
- ssd_out  out  11  {anode[3:0], seg[6:0]}; seg bit order is g,f,e,d,c,b,a (MSB to LSB).
- frame_done  out  1  one-cycle pulse when digit 3's slot ends.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - div_cnt=0, dig=0, active word=0, active half=0, pending empty.
  - data_ready=1, frame_done=0.
  - ssd_out=11'h7FF (all anodes off, all segments off, given SEG_ACTIVE_LOW=1).
  - Reset mid-frame discards both the pending and the active word.
- Divider:
  - div_cnt increments each clock and wraps to 0 after DIV_MAX.
  - tick = (div_cnt==DIV_MAX).
- Digit index:
  - dig (2 bits) advances on tick, 3 wraps to 0.
  - frame boundary = tick && dig==3. frame_done is registered and high the cycle after the boundary edge.
- Handshake:
  - data_ready is registered and equals !pending_full.
  - On valid && ready, capture {data_in, half_sel} into pending. pending_full=1, so data_ready=0 next cycle.
  - data_valid while data_ready=0 is ignored: no capture and no error.
- Promotion:
  - At a frame boundary with pending_full, active <= pending and pending_full <= 0.
  - A capture landing on the same edge as a boundary (pending was empty) is not promoted until the following boundary.
- Display value:
  - disp16 = active_half ? active[31:16] : active[15:0].
  - Digit d shows nibble disp16[4d+3:4d]; digit 0 is least significant and sits on anode[0].
- Output register:
  - ssd_out is registered and reflects the dig/active state of the previous cycle (1-clock latency).
  - anode = ~(4'b0001 << dig), i.e. exactly one anode low.
- Hex decode, active-high gfedcba:
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
  - 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71
  - With SEG_ACTIVE_LOW=1, seg is the bitwise inverse.
- Leading-zero blanking:
  - When blank_lz=1, digit d>0 is blanked (segments off, anode still driven) if nibbles d..3 are all zero.
  - Digit 0 is never blanked, so value 0 shows a single "0".
- No combinational path from data_in/data_valid to any output.

Test Plan:
- Reset (DIV_MAX=3 for all tests): hold reset_n=0 -> ssd_out=11'h7FF, data_ready=1, frame_done=0. Release -> the first edge gives ssd_out=11'b1110_1000000 (digit 0 shows "0"). frame_done pulses every 16 clocks.
- Load and promote: data_in=32'h0000_1234, half_sel=0, valid for 1 cycle.
  - data_ready=0 the next cycle; display stays 0 until the next frame boundary.
  - Then data_ready=1 and the digits cycle: an=1110 seg=0011001 ("4"); an=1101 seg=0110000 ("3"); an=1011 seg=0100100 ("2"); an=0111 seg=1111001 ("1").
- Back-pressure: present 32'h0000_1234, then 32'h0000_5678 held valid while data_ready=0.
  - The second word is not captured until after promotion.
  - It then captures and shows at the following boundary; no frame mixes digits of both words.
- Upper half: 32'hABCD_0000 with half_sel=1 -> digits 0..3 seg = 0100001 (d), 1000110 (C), 0000011 (b), 0001000 (A).
- Blanking: 32'h0000_0050, blank_lz=1 -> digits 3 and 2 have seg=7'h7F with their anodes low; digit 1 "5"=0010010; digit 0 "0"=1000000. With blank_lz=0, digits 3 and 2 show "0".
- Reset mid-operation: assert reset_n=0 during digit 2 with a word pending -> immediately ssd_out=11'h7FF and data_ready=1. After release the display shows 0 and the pending word is lost.
